// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the ALU / condition-code slice.
//   - alu_fun_e : operation select carried on alu_fun
//   - cond_fun_e: condition select carried on cond_fun
//   - CC_*      : bit positions of {ZF,SF,OF} inside the 3-bit cc word
//   - CC_RESET  : cc value after reset (zero flag set, others clear)
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fun_e;

  typedef enum logic [3:0] {
    COND_ALWAYS = 4'd0,
    COND_LE     = 4'd1,
    COND_L      = 4'd2,
    COND_E      = 4'd3,
    COND_NE     = 4'd4,
    COND_GE     = 4'd5,
    COND_G      = 4'd6
  } cond_fun_e;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational datapath, no state.
// Ports:
//   alu_fun [1:0]       operation select (ADD b+a, SUB b-a, AND, XOR)
//   a, b    [WIDTH-1:0] operands
//   result  [WIDTH-1:0] operation result, modulo 2^WIDTH
//   flags   [2:0]       {ZF,SF,OF} for that result
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [1:0]       alu_fun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] w_res;
  logic             w_of;

  // Operand order is deliberate: the machine computes valB op valA,
  // so subtraction is b - a and overflow is judged against b.
  always_comb begin
    w_res = '0;
    w_of  = 1'b0;
    case (alu_fun)
      ALU_ADD: begin
        w_res = b + a;
        w_of  = (a[MSB] == b[MSB]) && (w_res[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        w_res = b - a;
        w_of  = (a[MSB] != b[MSB]) && (w_res[MSB] != b[MSB]);
      end
      ALU_AND: w_res = b & a;
      ALU_XOR: w_res = b ^ a;
      default: w_res = '0;
    endcase
  end

  always_comb begin
    result       = w_res;
    flags        = '0;
    flags[CC_ZF] = (w_res == '0);
    flags[CC_SF] = w_res[MSB];
    flags[CC_OF] = w_of;
  end

endmodule

// File: rtl/alu_cc_unit.sv
// alu_cc_unit: ALU with a one-entry registered output stage and
// condition-code register.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operation handshake (in_ready is combinational)
//   alu_fun, a, b, set_cc operation, operands, cc-update enable
//   out_valid / out_ready result handshake
//   result [WIDTH-1:0]    registered result
//   cc [2:0]              registered {ZF,SF,OF}
//   cond_fun [3:0], cnd   condition select and its value on registered cc
module alu_cc_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_fun,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       cc,
  input  logic [3:0]       cond_fun,
  output logic             cnd
);

  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_cc;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_alu_res;
  logic [2:0]       w_alu_flags;
  logic             w_accept;
  logic             w_lt;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .alu_fun (alu_fun),
    .a       (a),
    .b       (b),
    .result  (w_alu_res),
    .flags   (w_alu_flags)
  );

  // The output register is freed in the same cycle it is drained, so a new
  // operation can be taken every cycle. Ready is also forced high while in
  // reset so the flag never depends on an unreset register.
  assign in_ready = !rst_n || !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Reset takes priority over any accept/consume at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_cc        <= CC_RESET;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_result    <= w_alu_res;
        if (set_cc) r_cc <= w_alu_flags;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign cc        = r_cc;

  // Conditions look only at the registered cc, so a flag update becomes
  // visible on cnd the cycle after the accepting edge.
  assign w_lt = r_cc[CC_SF] ^ r_cc[CC_OF];

  always_comb begin
    cnd = 1'b0;
    case (cond_fun)
      COND_ALWAYS: cnd = 1'b1;
      COND_LE:     cnd = w_lt | r_cc[CC_ZF];
      COND_L:      cnd = w_lt;
      COND_E:      cnd = r_cc[CC_ZF];
      COND_NE:     cnd = !r_cc[CC_ZF];
      COND_GE:     cnd = !w_lt;
      COND_G:      cnd = !w_lt && !r_cc[CC_ZF];
      default:     cnd = 1'b0;
    endcase
  end

endmodule
